// File: rtl/fifo_rd_packer.sv
// Read-side drain for the async FIFO: pops words and packs PACK_RATIO of them into one valid/ready beat.
// Optional partial-beat flush with lane mask is enabled by defining FIFO_PACK_FLUSH_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data
`ifdef FIFO_PACK_FLUSH_EN
  ,
  input  logic                             flush,
  output logic [PACK_RATIO-1:0]            m_keep
`endif
);
  localparam int CW = $clog2(PACK_RATIO);
  localparam int BW = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);

  logic [BW-1:0] acc;
  logic [CW-1:0] pk_cnt;
  logic          acc_full;
  logic          rd_pend;
  logic          out_busy;
  logic          last_in;
  logic          pop_block;
  logic [BW-1:0] full_beat;

  genvar gi;

  assign out_busy = m_valid & ~m_ready;
  assign last_in  = rd_pend & (pk_cnt == LAST_LANE);

  // The completing word bypasses acc straight into the top lane of the beat.
  generate
    for (gi = 0; gi < PACK_RATIO; gi++) begin : g_full_lane
      if (gi == PACK_RATIO - 1) begin : g_top
        assign full_beat[gi*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end else begin : g_low
        assign full_beat[gi*DATA_WIDTH +: DATA_WIDTH] = acc[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endgenerate

`ifdef FIFO_PACK_FLUSH_EN
  logic                  flush_pend;
  logic                  flush_emit;
  logic                  flush_drop;
  logic [PACK_RATIO-1:0] live;
  logic [BW-1:0]         part_beat;

  generate
    for (gi = 0; gi < PACK_RATIO; gi++) begin : g_part_lane
      assign live[gi] = (CW'(gi) < pk_cnt);
      assign part_beat[gi*DATA_WIDTH +: DATA_WIDTH] =
        live[gi] ? acc[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  // Pops stop on the flush pulse so the partial beat is frozen once the last in-flight word lands.
  assign pop_block  = flush | flush_pend;
  assign flush_emit = flush_pend & ~rd_pend & ~acc_full & ~out_busy & (pk_cnt != '0);
  assign flush_drop = flush_pend & ~rd_pend & ~acc_full & (pk_cnt == '0);
`else
  assign pop_block = 1'b0;
`endif

  assign fifo_rd_en = rd_rst_n & ~fifo_empty & ~acc_full & ~(last_in & out_busy) & ~pop_block;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      acc        <= '0;
      pk_cnt     <= '0;
      acc_full   <= 1'b0;
      rd_pend    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
`ifdef FIFO_PACK_FLUSH_EN
      m_keep     <= '0;
      flush_pend <= 1'b0;
`endif
    end else begin
      rd_pend <= fifo_rd_en;

      if (rd_pend) begin
        acc[int'(pk_cnt)*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
        pk_cnt <= last_in ? '0 : pk_cnt + CW'(1);
      end

      // A beat completing under backpressure parks in acc until the output slot frees.
      if (last_in && out_busy) begin
        acc_full <= 1'b1;
      end

      if (last_in && !out_busy) begin
        m_data  <= full_beat;
        m_valid <= 1'b1;
`ifdef FIFO_PACK_FLUSH_EN
        m_keep  <= '1;
`endif
      end else if (acc_full && !out_busy) begin
        m_data   <= acc;
        m_valid  <= 1'b1;
        acc_full <= 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
        m_keep   <= '1;
`endif
`ifdef FIFO_PACK_FLUSH_EN
      end else if (flush_emit) begin
        m_data  <= part_beat;
        m_valid <= 1'b1;
        m_keep  <= live;
        pk_cnt  <= '0;
`endif
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

`ifdef FIFO_PACK_FLUSH_EN
      if (flush) begin
        flush_pend <= 1'b1;
      end else if (flush_emit || flush_drop) begin
        flush_pend <= 1'b0;
      end
`endif
    end
  end

endmodule
